regfile_read_2r1w: RTL
======================

// Module: regfile_read_2r1w
// PURPOSE
//  MIPS-stub register file: 2^ADDR_WIDTH x DATA_WIDTH storage, one write port
//  (same write/data_in semantics as register_32bit) and two registered read
//  ports feeding decode. Read side is the consumer of register_32bit-style writes.
//  Sits between writeback (write port) and ID/EX operand latch (read ports).
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of data_in/data_a/data_b
//  ADDR_WIDTH  5   address width; NUM_REGS = 2**ADDR_WIDTH (32)
// PORTS
//  cclk      in   1           clock, all state updates on rising edge
//  rstb      in   1           reset, asynchronous, active-low
//  write     in   1           write enable, sampled at posedge cclk
//  waddr     in   ADDR_WIDTH  write register index
//  data_in   in   DATA_WIDTH  write data
//  rd_en     in   1           read request for raddr_a/raddr_b this cycle
//  raddr_a   in   ADDR_WIDTH  read index, port A (rs)
//  raddr_b   in   ADDR_WIDTH  read index, port B (rt)
//  stall     in   1           hold read outputs; blocks new read capture
//  data_a    out  DATA_WIDTH  registered read data, port A
//  data_b    out  DATA_WIDTH  registered read data, port B
//  rd_valid  out  1           data_a/data_b hold result of an accepted read
// BEHAVIOUR
//  - Reset (rstb=0, async): all NUM_REGS entries <= 0; data_a, data_b <= 0;
//    rd_valid <= 0. Reset asserted mid-read aborts it; no result ever appears.
//  - Write: posedge with write=1, rstb=1 -> mem[waddr] <= data_in. waddr=0
//    ignored; mem[0] is constant 0. Writes are independent of stall/rd_en.
//  - Read accept: posedge with rd_en=1 and stall=0 -> data_a <= mem[raddr_a],
//    data_b <= mem[raddr_b], rd_valid <= 1. Latency 1 cycle (addr at edge N,
//    data valid after edge N).
//  - No accept (rd_en=0, stall=0): rd_valid <= 0; data_a/data_b keep value.
//  - stall=1: data_a, data_b, rd_valid all hold; rd_en ignored (request lost,
//    requester re-presents after stall drops).
//  - Index 0 reads always return 0 on either port, bypass or not.
//  - raddr_a == raddr_b legal; both ports return identical data.
//  - Write and accepted read same edge, same nonzero index: result per
//    CONFIGURATION. Different index: read returns stored (pre-edge) value.
//  - Write data is visible to any read accepted on a later edge.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write/read same-edge collision forwards data_in
//    to the colliding port(s) (write-before-read, half-cycle regfile model).
//  REGFILE_BYPASS_EN undefined: colliding port returns old mem[] contents;
//    new value seen from next accepted read (read-before-write).
//  Only the collision case differs; all other behaviour identical.
// TESTING
//  T1 reset: rstb=0 then 1, read all 32 indices -> every data_a/data_b = 0.
//  T2 write/read: write r5=32'hDEADBEEF; next cycle rd_en, raddr_a=5,
//     raddr_b=0 -> after 1 edge data_a=DEADBEEF, data_b=0, rd_valid=1.
//  T3 r0: write=1 waddr=0 data_in=32'hFFFFFFFF; read raddr_a=0 -> data_a=0
//     (also with bypass build, same edge).
//  T4 collision: r7 holds 1; same edge write r7=2 and read raddr_a=7 ->
//     data_a=2 with REGFILE_BYPASS_EN, data_a=1 without; next read =2 both.
//  T5 stall: accept read r5 (DEADBEEF), then stall=1 for 3 cycles with
//     rd_en=1 raddr_a=7 -> data_a stays DEADBEEF, rd_valid stays 1; stall=0,
//     rd_en=0 -> rd_valid=0 next edge.
//  T6 reset mid-op: r3=32'h1234, rd_en=1 raddr_a=3, drop rstb before edge ->
//     data_a=0, rd_valid=0 immediately; after release read r3 -> 0.

Source files
------------

// File: rtl/regfile_read_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_2r1w
//  Brief    : 2^ADDR_WIDTH x DATA_WIDTH register file with one write port and
//             two registered, stallable read ports. Entry 0 is constant zero.
//             Optional same-edge write->read forwarding is selected by the
//             REGFILE_BYPASS_EN macro (undefined: read-before-write).
//  Revision : 1.0  initial release
// ============================================================================
module regfile_read_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  cclk,
    input  logic                  rstb,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  rd_valid
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage and its next-state
    logic [DATA_WIDTH-1:0] r_mem_q [c_NUM_REGS];
    logic [DATA_WIDTH-1:0] w_mem_d [c_NUM_REGS];

    // Read-port registers and their next-state
    logic [DATA_WIDTH-1:0] r_data_a_q;
    logic [DATA_WIDTH-1:0] r_data_b_q;
    logic                  r_rd_valid_q;
    logic [DATA_WIDTH-1:0] w_data_a_d;
    logic [DATA_WIDTH-1:0] w_data_b_d;
    logic                  w_rd_valid_d;

    // Read-side helpers
    logic                  w_rd_accept;
    logic                  w_fwd_a;
    logic                  w_fwd_b;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    // Write decode: update one entry; entry 0 is pinned to zero so it can
    // never hold anything else, which also makes index-0 reads return zero.
    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_mem_d[i] = r_mem_q[i];
        end
        if (write && (waddr != '0)) begin
            w_mem_d[waddr] = data_in;
        end
        w_mem_d[0] = '0;
    end

    // Storage array, cleared as a whole by reset
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

    // Collision detect: a write landing on a read index on the same edge.
    // Index 0 never forwards since writes to it are discarded.
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        w_fwd_a = write && (waddr == raddr_a) && (raddr_a != '0);
        w_fwd_b = write && (waddr == raddr_b) && (raddr_b != '0);
    end
`else
    always_comb begin
        w_fwd_a = 1'b0;
        w_fwd_b = 1'b0;
    end
`endif

    // Read mux with optional forwarding of the in-flight write data
    always_comb begin
        w_rd_a = w_fwd_a ? data_in : r_mem_q[raddr_a];
        w_rd_b = w_fwd_b ? data_in : r_mem_q[raddr_b];
    end

    // Read-port next state: stall freezes everything, otherwise rd_en
    // decides whether new data is captured; data holds when not accepted.
    always_comb begin
        w_rd_accept  = rd_en && !stall;
        w_data_a_d   = w_rd_accept ? w_rd_a : r_data_a_q;
        w_data_b_d   = w_rd_accept ? w_rd_b : r_data_b_q;
        w_rd_valid_d = stall ? r_rd_valid_q : rd_en;
    end

    // Read-port registers; reset aborts any in-flight read
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_data_a_q   <= '0;
            r_data_b_q   <= '0;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_data_a_q   <= w_data_a_d;
            r_data_b_q   <= w_data_b_d;
            r_rd_valid_q <= w_rd_valid_d;
        end
    end

    assign data_a   = r_data_a_q;
    assign data_b   = r_data_b_q;
    assign rd_valid = r_rd_valid_q;

endmodule
`default_nettype wire
